// File: rtl/io_cmd_sequencer.sv
// Command sequencer between the I/O block and the ALU: assembles operands/opcode from
// button presses and runs a start/done handshake with timeout. Optional: CMD_CHAIN_EN.
module io_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TO_W           = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] User_Input0,
  input  logic [3:0] User_Input1,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  input  logic       alu_underflow,
  output logic [3:0] Operand_A,
  output logic [3:0] Operand_B,
  output logic [3:0] Opcode,
  output logic       alu_start,
  output logic [7:0] Result,
  output logic       overflow,
  output logic       underflow,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'h0,
    S_A_LOADED  = 4'h1,
    S_B_LOADED  = 4'h2,
    S_OP_LOADED = 4'h3,
    S_BUSY      = 4'h4,
    S_DONE      = 4'h5,
    S_ERROR     = 4'hF
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      btn_q, rise_q;
  logic [TO_W-1:0] to_cnt;
  logic            press_a, press_b, press_op, press_go;
  logic            ld_a, ld_b, ld_op, ld_chain, launch, capture, to_inc;

  assign State = state_q;

  // A press counts only when exactly one button rose in that cycle.
  assign press_a  = (rise_q == 4'b0001);
  assign press_b  = (rise_q == 4'b0010);
  assign press_op = (rise_q == 4'b0100);
  assign press_go = (rise_q == 4'b1000);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_q  <= '1;
      rise_q <= '0;
    end else begin
      btn_q  <= User_Input1;
      rise_q <= User_Input1 & ~btn_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    ld_chain = 1'b0;
    launch   = 1'b0;
    capture  = 1'b0;
    to_inc   = 1'b0;
    case (state_q)
      S_BUSY: begin
        // The start cycle cannot carry a valid done; done beats the terminal count.
        if (alu_done && !alu_start) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: begin
        if (press_a) begin
          ld_a    = 1'b1;
          state_d = S_A_LOADED;
        end else if (press_b && state_q == S_A_LOADED) begin
          ld_b    = 1'b1;
          state_d = S_B_LOADED;
`ifdef CMD_CHAIN_EN
        end else if (press_b && state_q == S_DONE) begin
          ld_chain = 1'b1;
          state_d  = S_B_LOADED;
`endif
        end else if (press_op && state_q == S_B_LOADED) begin
          ld_op   = 1'b1;
          state_d = S_OP_LOADED;
        end else if (press_go && (state_q == S_OP_LOADED || state_q == S_DONE)) begin
          launch  = 1'b1;
          state_d = S_BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Operand_A <= '0;
      Operand_B <= '0;
      Opcode    <= '0;
      alu_start <= 1'b0;
      Result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      to_cnt    <= '0;
    end else begin
      alu_start <= launch;
      if (launch)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + 1'b1;
      if (ld_a) Operand_A <= User_Input0;
      if (ld_b) Operand_B <= User_Input0;
      if (ld_chain) begin
        Operand_A <= Result[3:0];
        Operand_B <= User_Input0;
      end
      if (ld_op) Opcode <= User_Input0;
      if (capture) begin
        Result    <= alu_result;
        overflow  <= alu_overflow;
        underflow <= alu_underflow;
      end
    end
  end

endmodule

// File: tb/tb_io_cmd_sequencer.sv
// Scoreboard bench for io_cmd_sequencer: stimulus pushes timed expected snapshots and
// launches from a rule-level model; a negedge monitor pops and compares them.
module tb_io_cmd_sequencer;

  localparam int T = 8;
`ifdef CMD_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  localparam logic [3:0] ST_IDLE = 4'h0, ST_A = 4'h1, ST_B = 4'h2, ST_OP = 4'h3,
                         ST_BUSY = 4'h4, ST_DONE = 4'h5, ST_ERR = 4'hF;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] User_Input0, User_Input1;
  logic       alu_done, alu_overflow, alu_underflow;
  logic [7:0] alu_result;
  logic [3:0] Operand_A, Operand_B, Opcode, State;
  logic       alu_start, overflow, underflow;
  logic [7:0] Result;

  io_cmd_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .User_Input0(User_Input0), .User_Input1(User_Input1),
    .alu_done(alu_done), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow), .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Opcode(Opcode), .alu_start(alu_start), .Result(Result), .overflow(overflow),
    .underflow(underflow), .State(State)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int due; logic [26:0] exp; } snap_t;
  typedef struct { int due; logic [11:0] ops; } launch_t;
  snap_t   snap_q[$];
  launch_t start_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers only
  logic [3:0] m_st, m_a, m_b, m_op;
  logic [7:0] m_res;
  logic       m_ovf, m_udf;

  task automatic push_snap(input int due, input logic start);
    snap_t s;
    s.due = due;
    s.exp = {m_st, m_a, m_b, m_op, m_res, m_ovf, m_udf, start};
    snap_q.push_back(s);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  always @(negedge CLK) begin : monitor
    snap_t       s;
    launch_t     l;
    logic [26:0] act;
    if (RST_N) begin
      if (start_q.size() > 0 && start_q[0].due < cyc) begin
        l = start_q.pop_front();
        checks++; errors++;
        $display("FAIL launch_missing: no alu_start seen, required at cycle %0d", l.due);
      end
      if (alu_start) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected: alu_start=1 at cycle %0d, required 0", cyc);
        end else begin
          l = start_q.pop_front();
          if (cyc != l.due || {Operand_A, Operand_B, Opcode} != l.ops || State != ST_BUSY) begin
            errors++;
            $display("FAIL launch: cycle %0d ops %h state %h, required cycle %0d ops %h state 4",
                     cyc, {Operand_A, Operand_B, Opcode}, State, l.due, l.ops);
          end
        end
      end
      while (snap_q.size() > 0 && snap_q[0].due <= cyc) begin
        s = snap_q.pop_front();
        act = {State, Operand_A, Operand_B, Opcode, Result, overflow, underflow, alu_start};
        checks++;
        if (act !== s.exp) begin
          errors++;
          $display("FAIL snapshot@%0d {st,a,b,op,res,ovf,udf,start}: got %h required %h",
                   cyc, act, s.exp);
        end
      end
    end
  end

  // One button action; if it launches, the bench plays the ALU with done delay d
  // (d outside 1..T-1 means no done, i.e. timeout) and presses btn0 while busy.
  task automatic press(input logic [3:0] mask, input logic [3:0] sw, input int d,
                       input logic [7:0] r, input logic ov, input logic un);
    int   n, fin;
    logic go, ok, bp;
    launch_t l;
    n  = cyc;
    go = 1'b0;
    User_Input0 = sw;
    User_Input1 = mask;
    push_snap(n + 1, 1'b0);
    if ($countones(mask) == 1) begin
      if (mask[0]) begin
        m_a = sw; m_st = ST_A;
      end else if (mask[1] && m_st == ST_A) begin
        m_b = sw; m_st = ST_B;
      end else if (mask[1] && m_st == ST_DONE && CHAIN) begin
        m_a = m_res[3:0]; m_b = sw; m_st = ST_B;
      end else if (mask[2] && m_st == ST_B) begin
        m_op = sw; m_st = ST_OP;
      end else if (mask[3] && (m_st == ST_OP || m_st == ST_DONE)) begin
        go = 1'b1;
      end
    end
    if (!go) begin
      push_snap(n + 2, 1'b0);
      wait_to(n + 2);
      User_Input1 = '0;
      wait_to(n + 4);
    end else begin
      ok  = (d >= 1 && d <= T - 1);
      bp  = !ok || d >= 2;
      fin = ok ? n + 3 + d : n + 2 + T;
      l.due = n + 2;
      l.ops = {m_a, m_b, m_op};
      start_q.push_back(l);
      m_st = ST_BUSY;
      push_snap(n + 2, 1'b1);
      push_snap(n + 3, 1'b0);
      if (fin - 1 > n + 3) push_snap(fin - 1, 1'b0);
      if (ok) begin
        m_res = r; m_ovf = ov; m_udf = un; m_st = ST_DONE;
      end else begin
        m_st = ST_ERR;
      end
      push_snap(fin, 1'b0);
      for (int c = n + 1; c < fin; c++) begin
        wait_to(c);
        User_Input1   = (c < n + 2) ? mask :
                        ((bp && c >= n + 3 && c < n + 5) ? 4'b0001 : 4'b0000);
        alu_done      = ok && (c == n + 2 + d);
        alu_result    = alu_done ? r : 8'($urandom);
        alu_overflow  = alu_done ? ov : 1'($urandom);
        alu_underflow = alu_done ? un : 1'($urandom);
      end
      wait_to(fin);
      User_Input1 = '0;
      alu_done    = 1'b0;
      wait_to(fin + 2);
    end
  endtask

  task automatic stray_done();
    int n;
    n = cyc;
    alu_done      = 1'b1;
    alu_result    = 8'($urandom);
    alu_overflow  = 1'($urandom);
    alu_underflow = 1'($urandom);
    push_snap(n + 1, 1'b0);
    push_snap(n + 2, 1'b0);
    wait_to(n + 1);
    alu_done = 1'b0;
    wait_to(n + 2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    int n, sel, k1, k2;
    User_Input0 = '0; User_Input1 = 4'b0001;
    alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0; alu_underflow = 1'b0;
    m_st = ST_IDLE; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_ovf = 1'b0; m_udf = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({State, Operand_A, Operand_B, Opcode, Result, overflow, underflow, alu_start} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0",
               {State, Operand_A, Operand_B, Opcode, Result, overflow, underflow, alu_start});
    end
    RST_N = 1'b1;
    n = cyc;
    push_snap(n + 3, 1'b0);
    wait_to(n + 3);
    User_Input1 = '0;
    wait_to(n + 5);

    press(4'b0011, 4'h6, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0001, 4'h7, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0100, 4'h9, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0001, 4'h3, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0010, 4'h5, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0100, 4'h2, 0, 8'h00, 1'b0, 1'b0);
    press(4'b1000, 4'h0, 3, 8'h08, 1'b0, 1'b0);
    stray_done();
    press(4'b1000, 4'h0, 5, 8'hFF, 1'b1, 1'b0);
    press(4'b1000, 4'h0, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0010, 4'h2, 0, 8'h00, 1'b0, 1'b0);
    press(4'b1000, 4'h0, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0001, 4'h4, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0010, 4'h8, 0, 8'h00, 1'b0, 1'b0);
    press(4'b0100, 4'h1, 0, 8'h00, 1'b0, 1'b0);
    press(4'b1000, 4'h0, T - 1, 8'h0C, 1'b0, 1'b1);
    press(4'b1000, 4'h0, 1, 8'h0C, 1'b0, 1'b0);
    press(4'b0010, 4'h1, 0, 8'h00, 1'b0, 1'b0);

    for (int it = 0; it < 200; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        k1 = $urandom_range(0, 3);
        press(4'b0001 << k1, 4'($urandom), $urandom_range(1, 9), 8'($urandom),
              1'($urandom), 1'($urandom));
      end else if (sel < 9) begin
        k1 = $urandom_range(0, 3);
        k2 = (k1 + $urandom_range(1, 3)) % 4;
        press((4'b0001 << k1) | (4'b0001 << k2), 4'($urandom), 1, 8'h00, 1'b0, 1'b0);
      end else begin
        stray_done();
      end
    end

    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (snap_q.size() != 0 || start_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending snapshots %0d launches %0d, required 0 0",
               snap_q.size(), start_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_cmd_sequencer.md
Name: io_cmd_sequencer

Overview:
- Consumes the debounced user-input bus produced by the I/O block: switch nibble and button nibble.
- Assembles operand A, operand B and opcode from the user inputs, then launches the ALU through a start/done handshake.
- Returns the captured 8-bit Result, the overflow/underflow flags and a 4-bit State code back to the I/O block for 7-segment/LED display.
- Sits between the I/O block and the ALU; it is the other end of the User_Input/Result/State interface.

Parameters:
TIMEOUT_CYCLES, 1000, max CLK cycles spent in BUSY waiting for alu_done before entering ERROR (must be ≥2)
TO_W, 16, width of the timeout counter (2^TO_W > TIMEOUT_CYCLES)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
User_Input0  input  4  slide-switch value (data nibble)
User_Input1  input  4  debounced button levels, [0]=load A, [1]=load B, [2]=load opcode, [3]=execute
alu_done  input  1  one-cycle pulse from ALU, result valid
alu_result  input  8  ALU result, valid with alu_done
alu_overflow  input  1  ALU overflow, valid with alu_done
alu_underflow  input  1  ALU underflow, valid with alu_done
Operand_A  output  4  latched operand A
Operand_B  output  4  latched operand B
Opcode  output  4  latched opcode
alu_start  output  1  one-cycle launch pulse
Result  output  8  captured ALU result
overflow  output  1  captured overflow flag
underflow  output  1  captured underflow flag
State  output  4  FSM state code for LED display

Behaviour:
- One clock domain, CLK. Reset is asynchronous, active-low (RST_N). All registers update on CLK rising edge.
- Reset values:
  - Operand_A, Operand_B, Opcode: 0.
  - alu_start: 0.
  - Result: 8'h00.
  - overflow, underflow: 0.
  - State: IDLE.
  - Timeout counter: 0.
  - Button history register: 4'b1111, so a button held through reset release does not count as a press.
- Press detection:
  - rise = User_Input1 & ~btn_q, where btn_q is the previous-cycle User_Input1.
  - If more than one rise bit is set in the same cycle, all are ignored.
- State codes: IDLE=4'h0, A_LOADED=4'h1, B_LOADED=4'h2, OP_LOADED=4'h3, BUSY=4'h4, DONE=4'h5, ERROR=4'hF. State output is registered.
- rise[0] in any state except BUSY: Operand_A<=User_Input0; go to A_LOADED. This also restarts entry from B_LOADED, OP_LOADED, DONE or ERROR.
- rise[1] in A_LOADED: Operand_B<=User_Input0; go to B_LOADED. Ignored in any other state (see optional feature for DONE).
- rise[2] in B_LOADED: Opcode<=User_Input0; go to OP_LOADED. Ignored elsewhere.
- rise[3] in OP_LOADED or DONE:
  - Assert alu_start for exactly one cycle, aligned with the entry into BUSY.
  - Clear the timeout counter.
  - From DONE this repeats the operation with the same operands. Ignored elsewhere.
- BUSY:
  - All button presses are ignored.
  - alu_done is sampled from the first BUSY cycle onward; a done pulse in the same cycle as alu_start is not possible by protocol and is ignored.
  - On alu_done: Result<=alu_result, overflow<=alu_overflow, underflow<=alu_underflow; go to DONE the next cycle.
  - Without alu_done the counter increments each cycle. When the counter reaches TIMEOUT_CYCLES-1 with no alu_done, go to ERROR.
  - If alu_done arrives on the terminal-count cycle, done wins and the FSM goes to DONE.
- ERROR: Result and the flags keep their previous values. Only rise[0] exits ERROR.
- alu_done outside BUSY is ignored, and Result/flags do not change.
- Operands, Opcode, Result and flags hold their values until explicitly reloaded. Result and flags are overwritten only by a done pulse received in BUSY.
- Latencies:
  - State update 2 cycles after a button level rises: 1 cycle for edge detection, 1 cycle for the FSM.
  - Result valid on the cycle State shows DONE.

Optional Feature:
CMD_CHAIN_EN
- Defined: rise[1] in DONE loads Operand_A<=Result[3:0] and Operand_B<=User_Input0, then goes to B_LOADED. This gives accumulator chaining; the Opcode is kept for re-entry or can be reloaded.
- Undefined: rise[1] in DONE is ignored; the state and all registers are unchanged.

Test Plan:
- Reset with User_Input1=4'b0001 held, then release RST_N → State stays 4'h0. Releasing and re-pressing btn0 with switches=4'h7 → Operand_A=7, State=4'h1.
- Sequence btn0(sw=3), btn1(sw=5), btn2(sw=2), btn3 → single-cycle alu_start, State=4'h4. ALU returns done, result=8'h08, ovf=0 → Result=8'h08, State=4'h5.
- Press btn0 and btn1 rising in the same cycle while in IDLE → no change. Then btn2 in A_LOADED → ignored, State stays 4'h1.
- In BUSY, press btn0 and pulse alu_done outside BUSY beforehand → buttons ignored, Result unchanged until the in-BUSY done. An ALU done with overflow=1, result=8'hFF → overflow=1, Result=8'hFF.
- TIMEOUT_CYCLES=8, no alu_done → State=4'hF exactly 8 cycles after the alu_start cycle, Result retains the prior value. btn0 then gives State=4'h1.
- DONE with Result=8'h0C: btn3 re-launches with identical operands. With CMD_CHAIN_EN, btn1 (sw=1) → Operand_A=4'hC, Operand_B=1, State=4'h2. Without the macro, State stays 4'h5.
